// File: rtl/dsp_fetch.sv
// dsp_fetch: instruction fetch unit for the 16-bit DSP core.
// Ports: clk/rst_n, imem req/gnt/rvalid bus, inst valid/ready to decode, redirect.
module dsp_fetch #(
  parameter logic [15:0] RESET_PC        = 16'h0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [15:0] inst_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [15:0]   pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] kill;
  logic [OW-1:0] out_nxt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_word [FIFO_DEPTH];
  logic [15:0]   fifo_pc   [FIFO_DEPTH];
  logic [15:0]   tag_q     [MAX_OUTSTANDING];
  logic [TW-1:0] tag_rd;
  logic [TW-1:0] tag_wr;
  logic          has_credit;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          pop;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // Only request when a FIFO slot is reserved for the reply,
  // so responses never need back-pressure.
  assign has_credit = (int'(outstanding) < MAX_OUTSTANDING) &&
                      (int'(fifo_count) + int'(outstanding) < FIFO_DEPTH);
  assign imem_req   = rst_n && !redirect && has_credit;
  assign imem_addr  = pc;
  assign grant      = imem_req && imem_gnt;
  // Stray responses for pre-reset requests are ignored.
  assign rsp        = imem_rvalid && (outstanding != '0);
  assign push       = rsp && (kill == '0) && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign out_nxt    = outstanding + OW'(grant) - OW'(rsp);

  assign inst_valid = (fifo_count != '0);
  assign inst_word  = fifo_word[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_word[i] <= '0;
        fifo_pc[i]   <= '0;
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      outstanding <= out_nxt;
      if (grant) begin
        tag_q[tag_wr] <= pc;
        tag_wr        <= tag_inc(tag_wr);
      end
      if (rsp) begin
        tag_rd <= tag_inc(tag_rd);
      end
      if (redirect) begin
        // Every request still in flight after this edge is stale.
        pc         <= redirect_pc;
        kill       <= out_nxt;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (grant) begin
          pc <= pc + 16'd1;
        end
        if (rsp && kill != '0) begin
          kill <= kill - OW'(1);
        end
        if (push) begin
          fifo_word[wr_ptr] <= imem_rdata;
          fifo_pc[wr_ptr]   <= tag_q[tag_rd];
          wr_ptr            <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_dsp_fetch.sv
// tb_dsp_fetch: self-checking bench for dsp_fetch.
// Memory model plus in-order scoreboard of granted addresses.
module tb_dsp_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_word;
  logic [15:0] inst_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit rand_gnt = 1'b0;
  int max_pend = 0;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;

  req_t        pending[$];
  logic [15:0] sb[$];
  logic [15:0] seen[$];
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  dsp_fetch #(
    .RESET_PC(16'h0010),
    .FIFO_DEPTH(2),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_word(inst_word),
    .inst_pc(inst_pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // memory driver: grant and in-order responses
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      imem_gnt    = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (rst_n && pending.size() > 0 && pending[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pending[0].addr);
        void'(pending.pop_front());
      end
    end
  end

  // monitor: record grants, compare delivered words
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending.delete();
        sb.delete();
      end else begin
        if (inst_valid && inst_ready && !redirect) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word pc=%h word=%h required none",
                     inst_pc, inst_word);
          end else begin
            exp_pc = sb.pop_front();
            if (inst_pc !== exp_pc || inst_word !== mem_word(exp_pc)) begin
              errors++;
              $display("FAIL delivered pc=%h word=%h required pc=%h word=%h",
                       inst_pc, inst_word, exp_pc, mem_word(exp_pc));
            end
          end
          seen.push_back(inst_pc);
        end
        if (redirect) begin
          sb.delete();
        end else if (imem_req && imem_gnt) begin
          sb.push_back(imem_addr);
          pending.push_back('{addr: imem_addr, due: cyc + lat});
          if (pending.size() > max_pend) max_pend = pending.size();
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_seen(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (seen.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (seen.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout seen=%0d required=%0d", name, seen.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    inst_ready = 1'b1;
    lat        = 1;
    rand_gnt   = 1'b0;
    redirect   = 1'b0;
    step(3);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got=%b required=0", imem_req);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got=%b required=0", inst_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen.delete();
    @(negedge clk);
    checks++;
    if (imem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL rst_addr got=%h required=0010", imem_addr);
    end
    checks++;
    if (inst_word !== 32'h0 || inst_pc !== 16'h0) begin
      errors++;
      $display("FAIL rst_out got=%h/%h required=0/0", inst_word, inst_pc);
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_req got=%b required=1", imem_req);
    end
  endtask

  task automatic test_stream();
    logic [15:0] e;
    step(24);
    checks++;
    if (seen.size() < 8) begin
      errors++;
      $display("FAIL stream_count got=%0d required>=8", seen.size());
    end
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      e = 16'h0010 + 16'(i);
      checks++;
      if (seen[i] !== e) begin
        errors++;
        $display("FAIL stream_pc[%0d] got=%h required=%h", i, seen[i], e);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] last;
    int          n0;
    last       = seen[$];
    n0         = seen.size();
    inst_ready = 1'b0;
    step(10);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_req got=%b required=0", imem_req);
    end
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_valid got=%b required=1", inst_valid);
    end
    checks++;
    if (seen.size() != n0) begin
      errors++;
      $display("FAIL stall_pop got=%0d required=%0d", seen.size(), n0);
    end
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    wait_seen(n0 + 2, 30, "stall_resume");
    checks++;
    if (seen[n0] !== last + 16'd1 || seen[n0+1] !== last + 16'd2) begin
      errors++;
      $display("FAIL stall_order got=%h,%h required=%h,%h",
               seen[n0], seen[n0+1], last + 16'd1, last + 16'd2);
    end
  endtask

  task automatic test_random();
    int n0;
    int bad;
    n0       = seen.size();
    max_pend = 0;
    rand_gnt = 1'b1;
    lat      = 3;
    step(200);
    rand_gnt = 1'b0;
    checks++;
    if (max_pend > 2 || max_pend < 1) begin
      errors++;
      $display("FAIL rand_outstanding got=%0d required=1..2", max_pend);
    end
    checks++;
    if (seen.size() < n0 + 10) begin
      errors++;
      $display("FAIL rand_count got=%0d required>=%0d", seen.size(), n0 + 10);
    end
    bad = 0;
    for (int i = (n0 > 0 ? n0 : 1); i < seen.size(); i++) begin
      if (seen[i] !== seen[i-1] + 16'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rand_increment got=%0d breaks required=0", bad);
    end
  endtask

  task automatic test_redirect();
    int n0;
    lat = 3;
    step(6);
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    n0          = seen.size();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_req got=%b required=0", imem_req);
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_valid got=%b required=0", inst_valid);
    end
    checks++;
    if (imem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL redir_addr got=%h required=0100", imem_addr);
    end
    wait_seen(n0 + 1, 40, "redir_first");
    checks++;
    if (seen[n0] !== 16'h0100) begin
      errors++;
      $display("FAIL redir_pc got=%h required=0100", seen[n0]);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    int bad;
    step(4);
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    n0          = seen.size();
    step(1);
    redirect_pc = 16'h0300;
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_addr !== 16'h0300 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_state got=%h/%b required=0300/0", imem_addr, inst_valid);
    end
    wait_seen(n0 + 3, 60, "b2b_words");
    checks++;
    if (seen[n0] !== 16'h0300) begin
      errors++;
      $display("FAIL b2b_first got=%h required=0300", seen[n0]);
    end
    bad = 0;
    for (int i = n0; i < seen.size(); i++) begin
      if (seen[i][15:8] == 8'h02) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_stale got=%0d words required=0", bad);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] wexp [4];
    int          n0;
    wexp        = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    lat         = 1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    n0          = seen.size();
    step(1);
    redirect = 1'b0;
    wait_seen(n0 + 4, 40, "wrap_words");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[n0+i] !== wexp[i]) begin
        errors++;
        $display("FAIL wrap_pc[%0d] got=%h required=%h", i, seen[n0+i], wexp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    step(3);
    rst_n = 1'b0;
    step(1);
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out got=%b/%b required=0/0", inst_valid, imem_req);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0    = seen.size();
    @(negedge clk);
    checks++;
    if (imem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL midrst_addr got=%h required=0010", imem_addr);
    end
    wait_seen(n0 + 1, 40, "midrst_first");
    checks++;
    if (seen[n0] !== 16'h0010) begin
      errors++;
      $display("FAIL midrst_pc got=%h required=0010", seen[n0]);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_random();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
